// File: rtl/pcie_dllp_transmitter_pkg.sv
// Shared PCIe data-link-layer definitions used by the DLLP transmitter and receiver.
// Holds the DLLP type codes, the flow-control enums, the framing symbols and the FSM state codes.
package pcie_dllp_transmitter_pkg;

   typedef enum logic [1:0] {
      FC_INIT1     = 2'd0,
      FC_INIT2     = 2'd1,
      FC_UPDATE    = 2'd2,
      FC_KIND_RSVD = 2'd3
   } fc_kind_e;

   typedef enum logic [1:0] {
      FC_P          = 2'd0,
      FC_NP         = 2'd1,
      FC_CPL        = 2'd2,
      FC_CLASS_RSVD = 2'd3
   } fc_class_e;

   localparam logic [7:0] DLLP_ACK      = 8'h00;
   localparam logic [7:0] DLLP_NAK      = 8'h10;
   localparam logic [7:0] DLLP_INITFC1  = 8'h40;
   localparam logic [7:0] DLLP_INITFC2  = 8'hC0;
   localparam logic [7:0] DLLP_UPDATEFC = 8'h80;

   localparam logic [7:0] SYM_SDP = 8'h5C;   // K28.2
   localparam logic [7:0] SYM_END = 8'hFD;   // K29.7

   localparam logic [15:0] CRC_POLY = 16'h100B;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_W0   = 3'd1;
   localparam logic [2:0] ST_W1   = 3'd2;
   localparam logic [2:0] ST_W2   = 3'd3;
   localparam logic [2:0] ST_W3   = 3'd4;

   function automatic logic fc_is_legal(input logic [1:0] kind, input logic [1:0] cls);
      return (kind != FC_KIND_RSVD) && (cls != FC_CLASS_RSVD);
   endfunction

   // Class selects the upper type nibble offset (P +0h, NP +10h, Cpl +20h), VC0 only.
   function automatic logic [7:0] fc_type_byte(input logic [1:0] kind, input logic [1:0] cls);
      logic [7:0] base;
      case (kind)
         FC_INIT1: base = DLLP_INITFC1;
         FC_INIT2: base = DLLP_INITFC2;
         default:  base = DLLP_UPDATEFC;
      endcase
      return base | {2'b00, cls, 4'h0};
   endfunction

   // Body layout: [31:24] byte0 (type, sent first) .. [7:0] byte3.
   function automatic logic [31:0] acknak_body(input logic is_nak, input logic [11:0] seq);
      return {(is_nak ? DLLP_NAK : DLLP_ACK), 8'h00, {4'h0, seq[11:8]}, seq[7:0]};
   endfunction

   function automatic logic [31:0] fc_body(input logic [1:0] kind, input logic [1:0] cls,
                                           input logic [7:0] hdr, input logic [11:0] data);
      return {fc_type_byte(kind, cls), {2'b00, hdr[7:2]}, {hdr[1:0], 2'b00, data[11:8]}, data[7:0]};
   endfunction

endpackage

// File: rtl/pcie_dllp_transmitter_crc.sv
// Combinational DLLP CRC-16 over the four body bytes; shared with the DLL receiver.
// Output [15:8] is the first CRC byte on the wire, [7:0] the second.
module PCIeDLLPCRC16
   import pcie_dllp_transmitter_pkg::*;
(
   input  logic [31:0] dllp_body,
   output logic [15:0] dllp_crc
);

   logic [15:0] lfsr;
   logic [15:0] inv;
   logic        fb;

   always_comb begin
      lfsr     = '1;
      fb       = 1'b0;
      inv      = '0;
      dllp_crc = '0;
      // Bytes go in wire order, each byte least-significant bit first.
      for (int unsigned i = 0; i < 4; i++) begin
         for (int unsigned j = 0; j < 8; j++) begin
            fb   = lfsr[15] ^ dllp_body[5'(24 - 8 * i + j)];
            lfsr = {lfsr[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
         end
      end
      inv = ~lfsr;
      // Remainder bit 15 lands in bit 0 of the first CRC byte, bit 0 in bit 7 of the second.
      for (int unsigned k = 0; k < 8; k++) begin
         dllp_crc[8 + k] = inv[15 - k];
         dllp_crc[k]     = inv[7 - k];
      end
   end

endmodule

// File: rtl/pcie_dllp_transmitter.sv
// Data-link-layer DLLP transmitter: frames Ack/Nak and flow-control DLLPs into SDP..END
// symbol pairs, coalesces Ack/Nak requests and yields the lane to SKP insertion.
module pcie_dllp_transmitter
   import pcie_dllp_transmitter_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        link_up,
   input  logic        acknak_valid,
   input  logic        acknak_is_nak,
   input  logic [11:0] acknak_seq,
   input  logic        fc_valid,
   output logic        fc_ready,
   input  logic [1:0]  fc_kind,
   input  logic [1:0]  fc_class,
   input  logic [7:0]  fc_hdr,
   input  logic [11:0] fc_data,
   input  logic        tx_skip_req,
   output logic        tx_skip_ack,
   input  logic        tx_skip_done,
   output logic [15:0] tx_data,
   output logic [1:0]  tx_charisk,
   output logic        busy
);

   logic [2:0]  state_q, state_d;
   logic        ack_pend_q, ack_pend_d;
   logic        ack_nak_q, ack_nak_d;
   logic [11:0] ack_seq_q, ack_seq_d;
   logic        skip_ack_q, skip_ack_d;
   logic [31:0] body_q, body_d;
   logic [15:0] crc_q, crc_d;
   logic [15:0] tx_data_d;
   logic [1:0]  tx_charisk_d;

   logic        ack_any;
   logic        start_slot;
   logic        start;
   logic        send_ack;
   logic        fc_take;
   logic        send_fc;
   logic        launch;
   logic [31:0] ack_body;
   logic [31:0] new_body;
   logic [15:0] crc_new;

   // A pending entry is always older than a same-cycle strobe, so it goes out first.
   always_comb begin
      ack_any    = ack_pend_q | acknak_valid;
      start_slot = (state_q == ST_IDLE) || (state_q == ST_W3);
      start      = rst_n & link_up & start_slot & ~tx_skip_req & ~skip_ack_q
                   & (ack_any | fc_valid);
      send_ack   = start & ack_any;
      fc_ready   = start & ~ack_pend_q & ~acknak_valid;
      fc_take    = fc_valid & fc_ready;
      send_fc    = fc_take & fc_is_legal(fc_kind, fc_class);
      launch     = send_ack | send_fc;
      ack_body   = ack_pend_q ? acknak_body(ack_nak_q, ack_seq_q)
                              : acknak_body(acknak_is_nak, acknak_seq);
      new_body   = send_ack ? ack_body : fc_body(fc_kind, fc_class, fc_hdr, fc_data);
      body_d     = launch ? new_body : body_q;
      crc_d      = launch ? crc_new : crc_q;
   end

   PCIeDLLPCRC16 u_crc (
      .dllp_body (new_body),
      .dllp_crc  (crc_new)
   );

   always_comb begin
      state_d = ST_IDLE;
      if (link_up) begin
         case (state_q)
            ST_IDLE: state_d = launch ? ST_W0 : ST_IDLE;
            ST_W0:   state_d = ST_W1;
            ST_W1:   state_d = ST_W2;
            ST_W2:   state_d = ST_W3;
            ST_W3:   state_d = launch ? ST_W0 : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output word is chosen from the next state so symbols leave straight from flops.
   always_comb begin
      tx_data_d    = '0;
      tx_charisk_d = 2'b00;
      case (state_d)
         ST_W0: begin
            tx_data_d    = {body_d[31:24], SYM_SDP};
            tx_charisk_d = 2'b01;
         end
         ST_W1: tx_data_d = {body_d[15:8], body_d[23:16]};
         ST_W2: tx_data_d = {crc_d[15:8], body_d[7:0]};
         ST_W3: begin
            tx_data_d    = {SYM_END, crc_d[7:0]};
            tx_charisk_d = 2'b10;
         end
         default: begin
            tx_data_d    = '0;
            tx_charisk_d = 2'b00;
         end
      endcase
   end

   always_comb begin
      ack_pend_d = ack_pend_q;
      ack_nak_d  = ack_nak_q;
      ack_seq_d  = ack_seq_q;
      if (!link_up) begin
         ack_pend_d = 1'b0;
      end else if (acknak_valid && (!send_ack || ack_pend_q)) begin
         ack_pend_d = 1'b1;
         ack_nak_d  = acknak_is_nak;
         ack_seq_d  = acknak_seq;
      end else if (send_ack) begin
         ack_pend_d = 1'b0;
      end
   end

   // A launch cannot coincide with a skip request, so W3 with skip_req never starts a DLLP.
   always_comb begin
      skip_ack_d = skip_ack_q;
      if (!link_up) begin
         skip_ack_d = 1'b0;
      end else if (skip_ack_q) begin
         if (tx_skip_done) skip_ack_d = 1'b0;
      end else if (tx_skip_req && start_slot) begin
         skip_ack_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ack_pend_q <= 1'b0;
         ack_nak_q  <= 1'b0;
         ack_seq_q  <= '0;
         skip_ack_q <= 1'b0;
         body_q     <= '0;
         crc_q      <= '0;
         tx_data    <= '0;
         tx_charisk <= 2'b00;
      end else begin
         state_q    <= state_d;
         ack_pend_q <= ack_pend_d;
         ack_nak_q  <= ack_nak_d;
         ack_seq_q  <= ack_seq_d;
         skip_ack_q <= skip_ack_d;
         body_q     <= body_d;
         crc_q      <= crc_d;
         tx_data    <= tx_data_d;
         tx_charisk <= tx_charisk_d;
      end
   end

   assign tx_skip_ack = skip_ack_q;
   assign busy        = (state_q != ST_IDLE) | ack_pend_q;

endmodule

// File: tb/tb_pcie_dllp_transmitter.sv
// Bench for pcie_dllp_transmitter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a word-slot reference model with a polynomial-division CRC.
module tb_pcie_dllp_transmitter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        link_up;
   logic        acknak_valid;
   logic        acknak_is_nak;
   logic [11:0] acknak_seq;
   logic        fc_valid;
   logic        fc_ready;
   logic [1:0]  fc_kind;
   logic [1:0]  fc_class;
   logic [7:0]  fc_hdr;
   logic [11:0] fc_data;
   logic        tx_skip_req;
   logic        tx_skip_ack;
   logic        tx_skip_done;
   logic [15:0] tx_data;
   logic [1:0]  tx_charisk;
   logic        busy;

   always #5 clk = ~clk;

   pcie_dllp_transmitter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .link_up       (link_up),
      .acknak_valid  (acknak_valid),
      .acknak_is_nak (acknak_is_nak),
      .acknak_seq    (acknak_seq),
      .fc_valid      (fc_valid),
      .fc_ready      (fc_ready),
      .fc_kind       (fc_kind),
      .fc_class      (fc_class),
      .fc_hdr        (fc_hdr),
      .fc_data       (fc_data),
      .tx_skip_req   (tx_skip_req),
      .tx_skip_ack   (tx_skip_ack),
      .tx_skip_done  (tx_skip_done),
      .tx_data       (tx_data),
      .tx_charisk    (tx_charisk),
      .busy          (busy)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: which of the four frame words is on the wire (0 = idle).
   int          m_slot;
   logic [15:0] m_wd [4];
   logic [1:0]  m_wk [4];
   bit          m_pend, m_pnak, m_skip, m_fc_ready;
   logic [11:0] m_pseq;
   logic [15:0] exp_data;
   logic [1:0]  exp_k;

   function automatic logic [7:0] bitrev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7 - i];
      return r;
   endfunction

   // Remainder of (seed * x^32 + msg * x^16) mod P, msg taken LSB-first per byte.
   function automatic logic [15:0] ref_crc(input logic [7:0] b0, b1, b2, b3);
      logic [7:0]  by [4];
      logic [31:0] msg;
      logic [47:0] v;
      logic [15:0] r;
      by[0] = b0; by[1] = b1; by[2] = b2; by[3] = b3;
      msg = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 8; j++) msg[31 - (i * 8 + j)] = by[i][j];
      v = {16'hFFFF, 32'h0} ^ {msg, 16'h0};
      for (int k = 47; k >= 16; k--)
         if (v[k]) v = v ^ (48'h1100B << (k - 16));
      r = ~v[15:0];
      return {bitrev8(r[15:8]), bitrev8(r[7:0])};
   endfunction

   task automatic ref_frame(input logic [7:0] b0, b1, b2, b3);
      logic [15:0] c;
      c = ref_crc(b0, b1, b2, b3);
      m_wd[0] = {b0, 8'h5C};     m_wk[0] = 2'b01;
      m_wd[1] = {b2, b1};        m_wk[1] = 2'b00;
      m_wd[2] = {c[15:8], b3};   m_wk[2] = 2'b00;
      m_wd[3] = {8'hFD, c[7:0]}; m_wk[3] = 2'b10;
   endtask

   task automatic ref_acknak(input bit nak, input logic [11:0] seq);
      ref_frame(nak ? 8'h10 : 8'h00, 8'h00, 8'(seq >> 8), 8'(seq & 12'hFF));
   endtask

   task automatic ref_fc(input logic [1:0] kind, input logic [1:0] cls,
                         input logic [7:0] hdr, input logic [11:0] data);
      logic [7:0] base [3];
      base[0] = 8'h40; base[1] = 8'hC0; base[2] = 8'h80;
      ref_frame(8'(base[kind] + 16 * cls), 8'(hdr >> 2),
                8'(((hdr & 8'h3) << 6) | (data >> 8)), 8'(data & 12'hFF));
   endtask

   function automatic bit model_can();
      return rst_n && link_up && (m_slot == 0 || m_slot == 4) && !tx_skip_req && !m_skip;
   endfunction

   task automatic model_step();
      bit can, ack_any, free, started;
      if (!rst_n || !link_up) begin
         m_slot = 0; m_pend = 0; m_skip = 0;
      end else begin
         can     = model_can();
         free    = (m_slot == 0 || m_slot == 4);
         ack_any = m_pend || acknak_valid;
         started = 0;
         if (can && ack_any) begin
            if (m_pend) ref_acknak(m_pnak, m_pseq);
            else        ref_acknak(acknak_is_nak, acknak_seq);
            started = 1;
            if (m_pend && acknak_valid) begin
               m_pnak = acknak_is_nak; m_pseq = acknak_seq;
            end else m_pend = 0;
         end else begin
            if (acknak_valid) begin
               m_pend = 1; m_pnak = acknak_is_nak; m_pseq = acknak_seq;
            end
            if (can && fc_valid && fc_kind != 2'd3 && fc_class != 2'd3) begin
               ref_fc(fc_kind, fc_class, fc_hdr, fc_data);
               started = 1;
            end
         end
         if (m_skip) begin
            if (tx_skip_done) m_skip = 0;
         end else if (tx_skip_req && free) m_skip = 1;
         if (started) m_slot = 1;
         else if (m_slot >= 1 && m_slot <= 3) m_slot++;
         else m_slot = 0;
      end
      exp_data = (m_slot == 0) ? 16'h0000 : m_wd[m_slot - 1];
      exp_k    = (m_slot == 0) ? 2'b00 : m_wk[m_slot - 1];
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle();
      #1;
      m_fc_ready = model_can() && fc_valid && !(m_pend || acknak_valid);
      check_eq("fc_ready", 32'(fc_ready), 32'(m_fc_ready));
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("tx_data", 32'(tx_data), 32'(exp_data));
      check_eq("tx_charisk", 32'(tx_charisk), 32'(exp_k));
      check_eq("tx_skip_ack", 32'(tx_skip_ack), 32'(m_skip));
      check_eq("busy", 32'(busy), 32'(m_slot != 0 || m_pend));
   endtask

   task automatic set_fc(input logic [1:0] kind, input logic [1:0] cls,
                         input logic [7:0] hdr, input logic [11:0] data);
      fc_valid = 1'b1; fc_kind = kind; fc_class = cls; fc_hdr = hdr; fc_data = data;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] c;
      rst_n = 1'b0; link_up = 1'b1;
      acknak_valid = 1'b0; acknak_is_nak = 1'b0; acknak_seq = '0;
      fc_valid = 1'b0; fc_kind = '0; fc_class = '0; fc_hdr = '0; fc_data = '0;
      tx_skip_req = 1'b0; tx_skip_done = 1'b0;
      m_slot = 0; m_pend = 0; m_pnak = 0; m_pseq = '0; m_skip = 0;
      exp_data = '0; exp_k = '0;
      for (int i = 0; i < 4; i++) begin m_wd[i] = '0; m_wk[i] = '0; end

      @(negedge clk);
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (6) cycle();

      // Single Ack, seq 123h
      acknak_valid = 1'b1; acknak_is_nak = 1'b0; acknak_seq = 12'h123;
      cycle();
      acknak_valid = 1'b0;
      check_eq("ack_w0", 32'(tx_data), 32'h005C);
      cycle();
      check_eq("ack_w1", 32'(tx_data), 32'h0100);
      cycle();
      c = ref_crc(8'h00, 8'h00, 8'h01, 8'h23);
      check_eq("ack_w2", 32'(tx_data), 32'({c[15:8], 8'h23}));
      cycle();
      check_eq("ack_w3", 32'(tx_data), 32'({8'hFD, c[7:0]}));
      cycle();
      check_eq("ack_idle", 32'(tx_data), 32'h0000);

      // Ack and UpdateFC/NP in the same cycle: Ack first, FC back-to-back
      acknak_valid = 1'b1; acknak_seq = 12'h001;
      set_fc(2'd2, 2'd1, 8'h25, 12'hABC);
      cycle();
      acknak_valid = 1'b0;
      repeat (3) cycle();
      cycle();
      fc_valid = 1'b0;
      check_eq("fc_w0", 32'(tx_data), 32'h905C);
      cycle();
      check_eq("fc_w1", 32'(tx_data), 32'h4A09);
      cycle();
      check_eq("fc_w2_lo", 32'(tx_data[7:0]), 32'hBC);
      repeat (3) cycle();

      // Three strobes during one in-flight DLLP coalesce into one Ack
      set_fc(2'd0, 2'd0, 8'h11, 12'h222);
      cycle();
      fc_valid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         acknak_valid = 1'b1; acknak_seq = 12'(12'h010 + s);
         cycle();
      end
      acknak_valid = 1'b0;
      cycle();
      check_eq("coal_w0", 32'(tx_data), 32'h005C);
      cycle(); cycle();
      check_eq("coal_seq", 32'(tx_data[7:0]), 32'h12);
      cycle(); cycle();
      check_eq("coal_single", 32'(tx_data), 32'h0000);

      // Skip request at W1 with another FC waiting
      set_fc(2'd1, 2'd2, 8'h3C, 12'h5A5);
      cycle();
      set_fc(2'd2, 2'd2, 8'h81, 12'h0F0);
      cycle();
      tx_skip_req = 1'b1;
      cycle(); cycle();
      cycle();
      check_eq("skip_ack_up", 32'(tx_skip_ack), 32'h1);
      tx_skip_req = 1'b0;
      repeat (3) cycle();
      tx_skip_done = 1'b1;
      cycle();
      tx_skip_done = 1'b0;
      cycle();
      fc_valid = 1'b0;
      check_eq("skip_fc_w0", 32'(tx_data), 32'hA05C);
      repeat (4) cycle();

      // link_up drop at W2 discards the pending Ack
      set_fc(2'd2, 2'd0, 8'hFF, 12'hFFF);
      cycle();
      fc_valid = 1'b0;
      acknak_valid = 1'b1; acknak_seq = 12'h777;
      cycle();
      acknak_valid = 1'b0;
      cycle();
      link_up = 1'b0;
      cycle();
      check_eq("linkdown_idle", 32'(tx_data), 32'h0000);
      link_up = 1'b1;
      repeat (4) cycle();
      check_eq("linkdown_no_ack", 32'(busy), 32'h0);

      // Asynchronous reset in the middle of a DLLP
      acknak_valid = 1'b1; acknak_seq = 12'h456;
      cycle();
      acknak_valid = 1'b0;
      cycle();
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_data", 32'(tx_data), 32'h0000);
      check_eq("rst_async_k", 32'(tx_charisk), 32'h0);
      cycle();
      rst_n = 1'b1;
      repeat (3) cycle();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         link_up       = ($urandom_range(0, 199) != 0);
         acknak_valid  = ($urandom_range(0, 99) < 12);
         acknak_is_nak = 1'($urandom);
         acknak_seq    = 12'($urandom);
         if (!fc_valid || m_fc_ready) begin
            fc_valid = ($urandom_range(0, 99) < 40);
            fc_kind  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            fc_class = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            fc_hdr   = 8'($urandom);
            fc_data  = 12'($urandom);
         end
         if (m_skip) tx_skip_req = 1'b0;
         else if (!tx_skip_req && $urandom_range(0, 99) < 3) tx_skip_req = 1'b1;
         tx_skip_done = m_skip && ($urandom_range(0, 99) < 30);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pcie_dllp_transmitter.md
PCIE_DLLP_TRANSMITTER -- requirements
Module: pcie_dllp_transmitter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (all logic on rising edge); rst_n input 1 (asynchronous active-low reset).
REQ-002 link_up  input  1  LTSSM reports L0; low aborts/suppresses all DLLP traffic.
REQ-003 acknak_valid  input  1  one-cycle strobe requesting an Ack/Nak DLLP; acknak_is_nak  input  1  1=Nak, 0=Ack; acknak_seq  input  12  AckNak_Seq_Num.
REQ-004 fc_valid  input  1 / fc_ready  output  1  valid/ready handshake for one flow-control DLLP.
REQ-005 fc_kind  input  2  0=InitFC1, 1=InitFC2, 2=UpdateFC, 3=reserved (dropped on accept); fc_class  input  2  0=P, 1=NP, 2=Cpl, 3=reserved (dropped on accept); fc_hdr  input  8  HdrFC; fc_data  input  12  DataFC.
REQ-006 tx_skip_req  input  1  output mux wants the lane for SKP; tx_skip_ack  output  1  lane released; tx_skip_done  input  1  SKP insertion finished.
REQ-007 tx_data  output  16  symbol pair, [7:0] transmitted first; tx_charisk  output  2  K flag per byte, bit0 for [7:0].
REQ-008 busy  output  1  high while a DLLP is in flight or an Ack/Nak is pending.

Function
REQ-009 The DLLP body SHALL be byte0 = type, bytes1..3 = fields: Ack 00h, Nak 10h, bytes {00h, {4'h0,seq[11:8]}, seq[7:0]}.
REQ-010 FC type byte SHALL be InitFC1 40h/50h/60h, InitFC2 C0h/D0h/E0h, UpdateFC 80h/90h/A0h for P/NP/Cpl (VC0); bytes {{2'b00,hdr[7:2]}, {hdr[1:0],2'b00,data[11:8]}, data[7:0]}.
REQ-011 CRC-16 SHALL be computed per PCIe base spec DLLP rules (poly 100Bh, seed FFFFh, spec bit ordering, complemented), then registered at latch.
REQ-012 Each DLLP SHALL occupy exactly four words: W0 {b0, SDP K28.2 5Ch}, W1 {b2, b1}, W2 {crc[15:8]-spec byte, b3}, W3 {END K29.7 FDh, crc low byte}; charisk 01b, 00b, 00b, 10b.
REQ-013 With nothing to send, outputs SHALL be logical idle: tx_data 0000h, tx_charisk 00b.
REQ-014 States: IDLE, W0, W1, W2, W3; W0->W1->W2->W3 unconditionally; W3->W0 if a start condition holds, else IDLE; IDLE->W0 on start condition.
REQ-015 Start condition (evaluated in IDLE or W3): link_up & !tx_skip_req & !tx_skip_ack & (acknak pending or fc_valid).
REQ-016 Outputs SHALL be registered; first symbol appears one cycle after the latch cycle; back-to-back DLLPs have no idle word between them.
REQ-017 Ack/Nak SHALL have priority over FC; fc_ready = start condition & !acknak pending & !acknak_valid.
REQ-018 Ack/Nak requests SHALL coalesce in one pending register: a later strobe overwrites is_nak and seq; a strobe in the cycle the pending entry is consumed becomes the new pending entry.
REQ-019 FC transfer occurs when fc_valid & fc_ready; fields latched that cycle; reserved kind/class consumed but no DLLP sent.
REQ-020 Skip: when tx_skip_req is high in IDLE, or in W3 with no DLLP started, tx_skip_ack SHALL rise next cycle and hold until the cycle after tx_skip_done; no DLLP starts while tx_skip_ack is high.
REQ-021 A DLLP in flight SHALL never be interrupted by tx_skip_req.
REQ-022 link_up falling SHALL return the FSM to IDLE next cycle, clear the Ack/Nak pending entry, deassert tx_skip_ack and drive idle; fc_ready low while link_up low.

Reset
REQ-023 On rst_n low: state IDLE, tx_data 0000h, tx_charisk 00b, fc_ready 0, tx_skip_ack 0, busy 0, pending cleared; operation resumes on the first clk edge after release.

Structure
REQ-024 DLLP type codes, fc_kind/fc_class enums, SDP/END symbol constants and the state enum SHALL live in a shared PCIe package used with the DLL receiver.
REQ-025 CRC SHALL be a separate combinational sub-module PCIeDLLPCRC16 (32-bit in, 16-bit out), reusable by the receiver.

Verification
REQ-026 Reset, link_up=1, no requests -> tx_data 0000h/charisk 00b every cycle; fc_ready=0.
REQ-027 acknak_valid, is_nak=0, seq=123h -> next cycles 005Ch/01, 0100h/00, {crc_hi,23h}/00, {FDh,crc_lo}/10; CRC equals bench model.
REQ-028 fc_valid UpdateFC/NP hdr=25h data=ABCh, same cycle acknak seq=001h -> Ack sent first, UpdateFC (type 90h, bytes 09h,4Ah,BCh) immediately follows, no idle word.
REQ-029 Three acknak strobes seq 10h,11h,12h during one in-flight DLLP -> exactly one following Ack with seq 012h.
REQ-030 tx_skip_req raised at W1 -> DLLP completes, tx_skip_ack rises after W3, pending FC held until cycle after tx_skip_done.
REQ-031 link_up dropped at W2 -> idle next cycle, pending Ack discarded, rst_n mid-DLLP -> immediate idle outputs.
